// File: rtl/stage_pkg.sv
// Shared widths and helpers for the stage1 3x3 convolution block.
// sat_int clamps a 32-bit signed value to the signed range of an arbitrary width.
package stage_pkg;

    localparam int INT_BITS     = 13;
    localparam int W_BITS       = 8;
    localparam int FRAC_BITS    = 6;
    localparam int TAPS         = 9;
    localparam int CONV_LATENCY = 3;

    function automatic logic signed [31:0] sat_int(input logic signed [31:0] x,
                                                   input int                 bits);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (bits - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/stage1_conv3x3_weight_bank.sv
// Serial 9-word weight loader with a shadow bank; the active bank is swapped in
// atomically on the ninth word so the datapath never sees a partial set.
module weight_bank
    import stage_pkg::*;
#(
    parameter int w_bits = W_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [w_bits-1:0]             w_in,
    input  logic                          w_valid,
    output logic [TAPS-1:0][w_bits-1:0]   active,
    output logic                          w_loaded
);

    logic [3:0]        wcnt;
    // The last word goes straight into active, so only eight shadow slots are needed.
    logic [w_bits-1:0] shadow [TAPS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt     <= '0;
            w_loaded <= 1'b0;
            active   <= '0;
            for (int i = 0; i < TAPS - 1; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            w_loaded <= 1'b0;
            if (w_valid) begin
                if (wcnt == 4'(TAPS - 1)) begin
                    for (int i = 0; i < TAPS - 1; i++) begin
                        active[i] <= shadow[i];
                    end
                    active[TAPS-1] <= w_in;
                    wcnt           <= '0;
                    w_loaded       <= 1'b1;
                end else begin
                    shadow[wcnt[2:0]] <= w_in;
                    wcnt              <= wcnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/stage1_conv3x3.sv
// 3x3 weighted sum of stage0 window taps: multiply, three partial sums, then
// total with round-half-up, arithmetic shift and saturation back to int_bits.
module stage1_conv3x3
    import stage_pkg::*;
#(
    parameter int int_bits  = INT_BITS,
    parameter int w_bits    = W_BITS,
    parameter int frac_bits = FRAC_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           latency_in,
    input  logic [TAPS-1:0][int_bits-1:0]  in,
    input  logic [w_bits-1:0]              w_in,
    input  logic                           w_valid,
    output logic [int_bits-1:0]            out,
    output logic                           latency_out,
    output logic                           w_loaded
);

    localparam int PROD_W = int_bits + w_bits;
    localparam int SUM_W  = PROD_W + 2;
    localparam int TOT_W  = PROD_W + 4;
    localparam logic signed [TOT_W-1:0] HALF = TOT_W'(1) <<< (frac_bits - 1);

    logic [TAPS-1:0][w_bits-1:0] active;

    logic                     vld_p0;
    logic                     vld_p1;
    logic                     vld_p2;
    logic signed [PROD_W-1:0] prod_p0 [TAPS];
    logic signed [SUM_W-1:0]  psum_p1 [3];
    logic signed [TOT_W-1:0]  sum_total;

    function automatic logic signed [TOT_W-1:0] round_shift(input logic signed [TOT_W-1:0] x);
        return (x + HALF) >>> frac_bits;
    endfunction

    function automatic logic [int_bits-1:0] sat_out(input logic signed [TOT_W-1:0] x);
        return int_bits'(sat_int(32'(x), int_bits));
    endfunction

    weight_bank #(
        .w_bits (w_bits)
    ) u_weight_bank (
        .clk      (clk),
        .reset    (reset),
        .w_in     (w_in),
        .w_valid  (w_valid),
        .active   (active),
        .w_loaded (w_loaded)
    );

    always_comb begin
        sum_total = TOT_W'(psum_p1[0]) + TOT_W'(psum_p1[1]) + TOT_W'(psum_p1[2]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            out    <= '0;
            for (int i = 0; i < TAPS; i++) begin
                prod_p0[i] <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                psum_p1[k] <= '0;
            end
        end else begin
            vld_p0 <= latency_in;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;

            // Stage A: per-tap products; weights are sampled here.
            if (latency_in) begin
                for (int i = 0; i < TAPS; i++) begin
                    prod_p0[i] <= PROD_W'($signed(in[i])) * PROD_W'($signed(active[i]));
                end
            end

            // Stage B: one partial sum per window row.
            if (vld_p0) begin
                for (int k = 0; k < 3; k++) begin
                    psum_p1[k] <= SUM_W'(prod_p0[3*k]) + SUM_W'(prod_p0[3*k+1])
                                + SUM_W'(prod_p0[3*k+2]);
                end
            end

            // Stage C: total, round, shift, saturate.
            if (vld_p1) begin
                out <= sat_out(round_shift(sum_total));
            end
        end
    end

    assign latency_out = vld_p2;

endmodule

// File: tb/tb_stage1_conv3x3.sv
// Directed bench for stage1_conv3x3: identity, rounding, saturation, reset during
// a partial load, gapped valids and a weight reload while streaming.
module tb_stage1_conv3x3;

    logic              clk = 1'b0;
    logic              reset;
    logic              latency_in;
    logic [8:0][12:0]  taps;
    logic [7:0]        w_in;
    logic              w_valid;
    logic signed [12:0] dout;
    logic              latency_out;
    logic              w_loaded;

    int passed = 0;
    int total  = 0;
    int wv [9];
    int pulses;
    logic last_wl;

    stage1_conv3x3 dut (
        .clk         (clk),
        .reset       (reset),
        .latency_in  (latency_in),
        .in          (taps),
        .w_in        (w_in),
        .w_valid     (w_valid),
        .out         (dout),
        .latency_out (latency_out),
        .w_loaded    (w_loaded)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 9; i++) taps[i] = 13'(v);
    endtask

    task automatic set_centre(input int v);
        for (int i = 0; i < 9; i++) taps[i] = 13'd0;
        taps[4] = 13'(v);
    endtask

    task automatic set_ramp(input int scale);
        for (int i = 0; i < 9; i++) taps[i] = 13'(scale * (i + 1));
    endtask

    // Loads wv; reports how many w_loaded pulses were seen and the value after word 9.
    task automatic load(output int npulse, output logic wl_last);
        npulse = 0;
        for (int i = 0; i < 9; i++) begin
            w_in    = 8'(wv[i]);
            w_valid = 1'b1;
            step();
            if (w_loaded) npulse++;
        end
        wl_last = w_loaded;
        w_valid = 1'b0;
        w_in    = 8'd0;
    endtask

    initial begin
        reset = 1'b1; latency_in = 1'b0; w_in = 8'd0; w_valid = 1'b0; set_all(0);
        step(); step();
        check("reset_out", dout, 0);
        check("reset_lo", 32'(latency_out), 0);
        check("reset_wl", 32'(w_loaded), 0);
        reset = 1'b0;
        step();

        // Identity: nine weights of 1.0, all taps 100.
        wv = '{64, 64, 64, 64, 64, 64, 64, 64, 64};
        load(pulses, last_wl);
        check("id_wl_pulses", pulses, 1);
        check("id_wl_after9", 32'(last_wl), 1);
        step();
        check("id_wl_drop", 32'(w_loaded), 0);
        set_all(100); latency_in = 1'b1;
        step();
        latency_in = 1'b0; set_all(0);
        check("id_lo_t1", 32'(latency_out), 0);
        step();
        check("id_lo_t2", 32'(latency_out), 0);
        step();
        check("id_lo_t3", 32'(latency_out), 1);
        check("id_out", dout, 900);
        step();
        check("id_lo_t4", 32'(latency_out), 0);
        check("id_hold", dout, 900);

        // Rounding with a single centre weight of 1/64.
        wv = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load(pulses, last_wl);
        check("rnd_wl_pulses", pulses, 1);
        latency_in = 1'b1;
        set_centre(32);  step();
        set_centre(31);  step();
        set_centre(-33); step();
        check("rnd_32", dout, 1);
        set_centre(-32); step();
        latency_in = 1'b0;
        check("rnd_31", dout, 0);
        step();
        check("rnd_m33", dout, -1);
        step();
        check("rnd_m32", dout, 0);
        check("rnd_lo", 32'(latency_out), 1);
        step();
        check("rnd_lo_end", 32'(latency_out), 0);

        // Saturation at both rails.
        wv = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
        load(pulses, last_wl);
        latency_in = 1'b1;
        set_all(4095);  step();
        set_all(-4096); step();
        latency_in = 1'b0;
        step();
        check("sat_hi", dout, 4095);
        step();
        check("sat_lo", dout, -4096);
        step(); step();

        // Partial load, reset, then a fresh full set of 1..9.
        wv = '{10, 20, 30, 40, 50, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            w_in = 8'(wv[i]); w_valid = 1'b1; step();
        end
        reset = 1'b1; w_in = 8'd99;
        step();
        check("prst_out", dout, 0);
        check("prst_lo", 32'(latency_out), 0);
        check("prst_wl", 32'(w_loaded), 0);
        reset = 1'b0; w_valid = 1'b0;
        wv = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load(pulses, last_wl);
        check("prst_wl_pulses", pulses, 1);
        check("prst_wl_after9", 32'(last_wl), 1);
        check("prst_out_idle", dout, 0);
        check("prst_lo_idle", 32'(latency_out), 0);
        set_ramp(64); latency_in = 1'b1;
        step();
        latency_in = 1'b0;
        step(); step();
        check("prst_lo", 32'(latency_out), 1);
        check("prst_result", dout, 285);
        step();

        // Gapped valids 1,0,1,1 under weights 1..9.
        set_all(64);  latency_in = 1'b1; step();
        set_all(640); latency_in = 1'b0; step();
        set_all(128); latency_in = 1'b1; step();
        check("gap_lo0", 32'(latency_out), 1);
        check("gap_out0", dout, 45);
        set_ramp(64); latency_in = 1'b1; step();
        latency_in = 1'b0; set_all(0);
        check("gap_lo1", 32'(latency_out), 0);
        check("gap_hold", dout, 45);
        step();
        check("gap_lo2", 32'(latency_out), 1);
        check("gap_out2", dout, 90);
        step();
        check("gap_lo3", 32'(latency_out), 1);
        check("gap_out3", dout, 285);
        step();
        check("gap_lo4", 32'(latency_out), 0);
        check("gap_hold_end", dout, 285);

        // Reload to all-zero weights while streaming continuously.
        wv = '{64, 64, 64, 64, 64, 64, 64, 64, 64};
        load(pulses, last_wl);
        set_all(100); latency_in = 1'b1;
        for (int j = 0; j < 16; j++) begin
            w_valid = (j < 9);
            w_in    = 8'd0;
            step();
            if (j == 8) check("mid_wl", 32'(w_loaded), 1);
            if (j >= 2) begin
                check($sformatf("mid_lo_%0d", j), 32'(latency_out), 1);
                check($sformatf("mid_out_%0d", j), dout, (j <= 10) ? 900 : 0);
            end
        end
        w_valid = 1'b0; latency_in = 1'b0;
        step(); step(); step();
        check("mid_drain_lo", 32'(latency_out), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
